// File: rtl/captura_rtc_ctrl_pkg.sv
// Shared definitions for the per-frame RTC snapshot sequencer: slot count,
// RTC register address table and FSM state encoding.
package captura_rtc_ctrl_pkg;

    localparam int N_SLOTS      = 11;
    localparam int V_ACTIVE_DEF = 480;
    localparam int TIMEOUT_DEF  = 63;

    // sec, min, hour, date, month, year, weekday, week-number, tsec, tmin, thour
    localparam logic [7:0] ADDR_TBL [0:N_SLOTS-1] = '{
        8'h00, 8'h02, 8'h04, 8'h07, 8'h08, 8'h09,
        8'h06, 8'h0B, 8'h20, 8'h21, 8'h22
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_GAP    = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/captura_rtc_ctrl.sv
// Reads the 11 RTC/timer BCD registers into a shadow buffer at the start of
// vertical blanking and commits them to datos_o in a single cycle.
module captura_rtc_ctrl
    import captura_rtc_ctrl_pkg::*;
#(
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixely,
    input  logic        hold,
    input  logic        clr_err,
    output logic        rd_req,
    output logic [7:0]  rd_addr,
    input  logic        rd_ack,
    input  logic [7:0]  rd_data,
    output logic [87:0] datos_o,
    output logic        commit,
    output logic        overrun,
    output logic        timeout_err
);

    state_t      state_q, state_d;
    logic [3:0]  slot_q, slot_d;
    logic [5:0]  tmo_q, tmo_d;
    logic        vb_dly_q;
    logic [7:0]  shadow_q [N_SLOTS];
    logic [7:0]  shadow_d [N_SLOTS];
    logic [87:0] datos_q, datos_d;
    logic        commit_q, commit_d;
    logic        overrun_q, overrun_d;
    logic        tmo_err_q, tmo_err_d;

    logic        vblank;
    logic        vb_rise;
    logic        ov_set;
    logic        te_set;

    assign vblank  = (pixely >= 10'(V_ACTIVE));
    assign vb_rise = vblank & ~vb_dly_q;

    // Request drops combinationally the moment blanking ends, before the FSM reacts.
    assign rd_req      = (state_q == ST_REQ) & vblank;
    assign rd_addr     = rd_req ? ADDR_TBL[slot_q] : 8'h00;
    assign datos_o     = datos_q;
    assign commit      = commit_q;
    assign overrun     = overrun_q;
    assign timeout_err = tmo_err_q;

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        tmo_d    = tmo_q;
        shadow_d = shadow_q;
        datos_d  = datos_q;
        commit_d = 1'b0;
        ov_set   = 1'b0;
        te_set   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (vb_rise && !hold) begin
                    state_d = ST_REQ;
                    slot_d  = 4'd0;
                    tmo_d   = 6'd0;
                end
            end
            ST_REQ: begin
                if (!vblank) begin
                    ov_set  = 1'b1;
                    state_d = ST_IDLE;
                end else if (rd_ack) begin
                    shadow_d[slot_q] = rd_data;
                    state_d          = ST_GAP;
                end else begin
                    // A timed-out slot keeps the value from the previous frame.
                    if (tmo_q == 6'(TIMEOUT)) begin
                        te_set  = 1'b1;
                        state_d = ST_GAP;
                    end
                    if (tmo_q != 6'h3F) begin
                        tmo_d = tmo_q + 6'd1;
                    end
                end
            end
            ST_GAP: begin
                if (!vblank) begin
                    ov_set  = 1'b1;
                    state_d = ST_IDLE;
                end else if (slot_q == 4'(N_SLOTS - 1)) begin
                    state_d = ST_COMMIT;
                end else begin
                    slot_d  = slot_q + 4'd1;
                    tmo_d   = 6'd0;
                    state_d = ST_REQ;
                end
            end
            ST_COMMIT: begin
                for (int k = 0; k < N_SLOTS; k++) begin
                    datos_d[8*k +: 8] = shadow_q[k];
                end
                commit_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Set takes priority over a simultaneous clear.
        overrun_d = ov_set | (overrun_q & ~clr_err);
        tmo_err_d = te_set | (tmo_err_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            slot_q    <= 4'd0;
            tmo_q     <= 6'd0;
            vb_dly_q  <= 1'b0;
            datos_q   <= '0;
            commit_q  <= 1'b0;
            overrun_q <= 1'b0;
            tmo_err_q <= 1'b0;
            for (int k = 0; k < N_SLOTS; k++) begin
                shadow_q[k] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            tmo_q     <= tmo_d;
            vb_dly_q  <= vblank;
            datos_q   <= datos_d;
            commit_q  <= commit_d;
            overrun_q <= overrun_d;
            tmo_err_q <= tmo_err_d;
            shadow_q  <= shadow_d;
        end
    end

endmodule

// File: tb/tb_captura_rtc_ctrl.sv
// Scoreboard bench for captura_rtc_ctrl: a reactive RTC responder drives the
// req/ack port while a monitor checks every commit against a frame model.
module tb_captura_rtc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  pixely = 10'd0;
    logic        hold = 1'b0;
    logic        clr_err = 1'b0;
    logic        rd_ack = 1'b0;
    logic [7:0]  rd_data = 8'h00;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic [87:0] datos_o;
    logic        commit;
    logic        overrun;
    logic        timeout_err;

    captura_rtc_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .pixely      (pixely),
        .hold        (hold),
        .clr_err     (clr_err),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .datos_o     (datos_o),
        .commit      (commit),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [87:0] datos;
        int          lat;
    } exp_t;

    exp_t        sb_q [$];
    int          start_cyc = 0;
    logic [87:0] last_frame = '0;
    int          plan_dly [11];
    logic [7:0]  plan_dat [11];

    localparam logic [7:0] ADDR_REF [0:10] = '{
        8'h00, 8'h02, 8'h04, 8'h07, 8'h08, 8'h09,
        8'h06, 8'h0B, 8'h20, 8'h21, 8'h22
    };

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every commit pulse must match the oldest expected frame.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && commit === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("commit_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("datos_o", datos_o, e.datos);
                check("latency", cyc - start_cyc, e.lat);
            end
        end
    end

    task automatic wait_req(output bit ok);
        int n;
        n = 0;
        while (rd_req !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 300);
        if (!ok) check("req_wait", 0, 1);
    endtask

    // plan_dly[k]==0 means slot k is never acked; otherwise ack on REQ cycle plan_dly[k].
    task automatic run_frame(input int abort_slot, input int clr_slot, input int hold_slot);
        logic [87:0] exp;
        int          lat;
        int          n;
        bit          ok;
        pixely = 10'($urandom_range(0, 479));
        repeat (3) @(negedge clk);
        exp = last_frame;
        lat = 2;
        for (int k = 0; k < 11; k++) begin
            if (plan_dly[k] == 0) begin
                lat += 65;
            end else begin
                lat += plan_dly[k] + 1;
                exp[8*k +: 8] = plan_dat[k];
            end
        end
        start_cyc = cyc;
        pixely = 10'(480 + $urandom_range(0, 40));
        if (abort_slot < 0) begin
            sb_q.push_back('{exp, lat});
            last_frame = exp;
        end
        for (int k = 0; k < 11; k++) begin
            wait_req(ok);
            if (!ok) begin
                hold = 1'b0;
                return;
            end
            check("rd_addr", rd_addr, ADDR_REF[k]);
            if (k == hold_slot) hold = 1'b1;
            if (k == abort_slot) begin
                pixely  = 10'($urandom_range(0, 479));
                rd_ack  = 1'b1;
                rd_data = 8'hEE;
                #1;
                check("abort_req_drop", rd_req, 0);
                @(negedge clk);
                rd_ack = 1'b0;
                check("overrun_set", overrun, 1);
                check("datos_kept", datos_o, last_frame);
                repeat (5) @(negedge clk);
                hold = 1'b0;
                return;
            end
            if (plan_dly[k] == 0) begin
                for (int i = 1; i <= 64; i++) begin
                    if (i == 64 && k == clr_slot) clr_err = 1'b1;
                    @(negedge clk);
                end
                clr_err = 1'b0;
                check("tmo_req_drop", rd_req, 0);
            end else begin
                repeat (plan_dly[k] - 1) @(negedge clk);
                rd_ack  = 1'b1;
                rd_data = plan_dat[k];
                @(negedge clk);
                rd_ack  = 1'b0;
            end
        end
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("commit_wait", 0, 1);
            sb_q.delete();
        end
        hold = 1'b0;
    endtask

    task automatic plan_fixed(input int dly, input int base);
        for (int k = 0; k < 11; k++) begin
            plan_dly[k] = dly;
            plan_dat[k] = 8'(base + k);
        end
    endtask

    initial begin
        int n;
        bit ok;

        repeat (2) @(negedge clk);
        check("reset_state", {rd_req, rd_addr, datos_o, commit, overrun, timeout_err}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Ack on second REQ cycle, data 0x10+k.
        plan_fixed(2, 8'h10);
        run_frame(-1, -1, -1);
        check("no_err_after_clean", {overrun, timeout_err}, 0);

        // Slot 3 never acked: skipped, keeps previous value, commit still fires.
        plan_fixed(2, 8'h20);
        plan_dly[3] = 0;
        run_frame(-1, -1, -1);
        check("timeout_err_set", timeout_err, 1);

        // Blanking ends during slot 6 request (after slot 5 acked).
        plan_fixed(1, 8'h30);
        run_frame(6, -1, -1);
        plan_fixed(1, 8'h40);
        run_frame(-1, -1, -1);

        // clr_err alone clears both sticky flags.
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_overrun", overrun, 0);
        check("clr_timeout_err", timeout_err, 0);

        // clr_err coinciding with a timeout: set wins.
        plan_fixed(1, 8'h50);
        plan_dly[2] = 0;
        run_frame(-1, 2, -1);
        check("set_beats_clr", timeout_err, 1);
        check("overrun_still_clear", overrun, 0);

        // hold at vb_rise skips the frame entirely.
        pixely = 10'd100;
        repeat (3) @(negedge clk);
        hold = 1'b1;
        pixely = 10'd490;
        repeat (2) @(negedge clk);
        hold = 1'b0;
        n = 0;
        repeat (40) begin
            if (rd_req === 1'b1) n++;
            @(negedge clk);
        end
        check("hold_skip_req", n, 0);

        // hold raised mid-capture does not stop it.
        plan_fixed(3, 8'h60);
        run_frame(-1, -1, 3);

        // Asynchronous reset during slot 7 request.
        pixely = 10'd10;
        repeat (3) @(negedge clk);
        pixely = 10'd500;
        for (int k = 0; k < 7; k++) begin
            wait_req(ok);
            rd_ack  = 1'b1;
            rd_data = 8'h77;
            @(negedge clk);
            rd_ack  = 1'b0;
        end
        wait_req(ok);
        check("rd_addr_slot7", rd_addr, ADDR_REF[7]);
        reset = 1'b0;
        #1;
        check("reset_async_outputs", {rd_req, rd_addr, datos_o, commit, overrun, timeout_err}, 0);
        last_frame = '0;
        pixely = 10'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        repeat (20) begin
            if (rd_req === 1'b1) n++;
            @(negedge clk);
        end
        check("post_reset_idle", n, 0);

        // Randomised frames.
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 11; k++) begin
                plan_dly[k] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
                plan_dat[k] = 8'($urandom);
            end
            run_frame(-1, -1, -1);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
